// File: rtl/d_ff_en.sv
// d_ff_en: WIDTH-bit D flip-flop with synchronous load enable and asynchronous active-high reset
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, forces q to RST_VAL
//   d      : data captured on an enabled rising edge
//   enable : active-high load enable, sampled on the rising edge
//   q      : registered state, driven straight from the storage element
module d_ff_en #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);
  if (WIDTH < 1) begin : g_bad_width
    $error("d_ff_en: WIDTH must be >= 1");
  end
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = enable ? d : q_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q_q <= RST_VAL;
    else       q_q <= q_d;
  assign q = q_q;
endmodule

// File: tb/tb_d_ff_en.sv
// tb_d_ff_en: randomized self-checking bench for d_ff_en at widths 1, 64 and 8 (non-zero reset value)
module tb_d_ff_en;
  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, d1 = 1'b0;
  logic [63:0] d64 = '0;
  logic [7:0]  d8 = '0;
  logic        q1, e1;
  logic [63:0] q64, e64;
  logic [7:0]  q8, e8;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  d_ff_en u1 (.clk(clk), .reset(reset), .d(d1), .enable(enable), .q(q1));
  d_ff_en #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .d(d64), .enable(enable), .q(q64));
  d_ff_en #(.WIDTH(8), .RST_VAL(8'hA5)) u8 (.clk(clk), .reset(reset), .d(d8), .enable(enable), .q(q8));

  // Reference: reset forces the reset value at once; otherwise an edge loads d when enabled.
  task automatic set_reset(input logic r);
    reset = r;
    if (r) begin
      e1 = 1'b0; e64 = '0; e8 = 8'hA5;
    end
  endtask

  task automatic step();
    if (!reset && enable) begin
      e1 = d1; e64 = d64; e8 = d8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    enable = 1'b1; d1 = 1'b1; d64 = {$urandom, $urandom}; d8 = 8'($urandom);
    set_reset(1'b1);
    #1;
    checks++;
    if ({q1, q64, q8} !== {e1, e64, e8}) begin
      fails++;
      $display("FAIL reset_now: got %b %h %h want %b %h %h", q1, q64, q8, e1, e64, e8);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({q1, q64, q8} !== {e1, e64, e8}) begin
        fails++;
        $display("FAIL reset_held[%0d]: got %b %h %h want %b %h %h", i, q1, q64, q8, e1, e64, e8);
      end
    end
  endtask

  task automatic test_async_reset();
    set_reset(1'b0);
    enable = 1'b1; d1 = 1'b1; d8 = 8'h3C;
    step();
    checks++;
    if (q1 !== 1'b1 || q8 !== 8'h3C) begin
      fails++;
      $display("FAIL async_preload: got %b %h want 1 3c", q1, q8);
    end
    #3;
    set_reset(1'b1);
    #1;
    checks++;
    if (q1 !== 1'b0 || q8 !== 8'hA5) begin
      fails++;
      $display("FAIL async_midcycle: got %b %h want 0 a5", q1, q8);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q1 !== 1'b0 || q8 !== 8'hA5) begin
        fails++;
        $display("FAIL async_hold[%0d]: got %b %h want 0 a5", i, q1, q8);
      end
    end
  endtask

  task automatic test_hold();
    set_reset(1'b0);
    enable = 1'b0; d1 = 1'b1; d64 = '1; d8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({q1, q64, q8} !== {1'b0, 64'h0, 8'hA5}) begin
        fails++;
        $display("FAIL hold[%0d]: got %b %h %h want 0 0 a5", i, q1, q64, q8);
      end
    end
    for (int i = 0; i < 3; i++) begin
      d1 = i[0];
      enable = i[0];
      #2;
      checks++;
      if (q1 !== 1'b0) begin
        fails++;
        $display("FAIL hold_no_edge[%0d]: got %b want 0", i, q1);
      end
    end
    enable = 1'b0;
    step();
    checks++;
    if (q1 !== 1'b0) begin
      fails++;
      $display("FAIL hold_after_toggle: got %b want 0", q1);
    end
  endtask

  task automatic test_load();
    enable = 1'b1; d1 = 1'b1;
    step();
    checks++;
    if (q1 !== 1'b1) begin
      fails++;
      $display("FAIL load_one: got %b want 1", q1);
    end
    d1 = 1'b0;
    step();
    checks++;
    if (q1 !== 1'b0) begin
      fails++;
      $display("FAIL load_zero: got %b want 0", q1);
    end
  endtask

  task automatic test_enable_drop();
    enable = 1'b1; d1 = 1'b1;
    step();
    enable = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q1 !== 1'b1) begin
        fails++;
        $display("FAIL enable_drop[%0d]: got %b want 1", i, q1);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (q1 !== 1'b0) begin
      fails++;
      $display("FAIL reenable: got %b want 0", q1);
    end
  endtask

  task automatic test_reset_priority();
    enable = 1'b1; d1 = 1'b1; d8 = 8'h5A;
    set_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q1 !== 1'b0 || q8 !== 8'hA5) begin
        fails++;
        $display("FAIL prio_reset[%0d]: got %b %h want 0 a5", i, q1, q8);
      end
    end
    #3;
    set_reset(1'b0);
    step();
    checks++;
    if (q1 !== 1'b1 || q8 !== 8'h5A) begin
      fails++;
      $display("FAIL prio_release: got %b %h want 1 5a", q1, q8);
    end
  endtask

  task automatic test_wide();
    logic [63:0] dv[4] = '{64'hAB, 64'hCAB, 64'h8CAB, 64'h0};
    logic        ev[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] qv[4] = '{64'h0, 64'hCAB, 64'h8CAB, 64'h0};
    set_reset(1'b1);
    #2;
    set_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      d64 = dv[i]; enable = ev[i];
      step();
      checks++;
      if (q64 !== qv[i]) begin
        fails++;
        $display("FAIL wide[%0d]: got %h want %h", i, q64, qv[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_reset($urandom_range(0, 15) == 0);
      enable = 1'($urandom); d1 = 1'($urandom); d64 = {$urandom, $urandom}; d8 = 8'($urandom);
      step();
      checks++;
      if ({q1, q64, q8} !== {e1, e64, e8}) begin
        fails++;
        $display("FAIL random[%0d]: got %b %h %h want %b %h %h", i, q1, q64, q8, e1, e64, e8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_hold();
    test_load();
    test_enable_drop();
    test_reset_priority();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
